// File: rtl/s15850_n510_vec_driver_if.sv
// Handshake and data bundle between the n510 vector driver and its environment.
// Macro S15850_N510_RESP_COMPARE_EN adds the expected-response compare signals.
interface s15850_n510_vec_driver_if #(
    parameter int VEC_W = 21
);
    logic             start;
    logic             scan_in;
    logic             scan_en;
    logic [VEC_W-1:0] vec_out;
    logic             cone_resp;
    logic             resp_out;
    logic             resp_valid;
    logic             resp_ready;
    logic             busy;
    logic             done;
    logic [15:0]      vec_count;
`ifdef S15850_N510_RESP_COMPARE_EN
    logic             exp_resp;
    logic             mismatch;
    logic [7:0]       mismatch_cnt;

    modport slave (
        input  start, scan_in, scan_en, cone_resp, resp_ready, exp_resp,
        output vec_out, resp_out, resp_valid, busy, done, vec_count, mismatch, mismatch_cnt
    );
    modport master (
        output start, scan_in, scan_en, cone_resp, resp_ready, exp_resp,
        input  vec_out, resp_out, resp_valid, busy, done, vec_count, mismatch, mismatch_cnt
    );
`else
    modport slave (
        input  start, scan_in, scan_en, cone_resp, resp_ready,
        output vec_out, resp_out, resp_valid, busy, done, vec_count
    );
    modport master (
        output start, scan_in, scan_en, cone_resp, resp_ready,
        input  vec_out, resp_out, resp_valid, busy, done, vec_count
    );
`endif
endinterface

// File: rtl/s15850_n510_vec_driver.sv
// Serial-load / parallel-apply driver for the s15850 n510 cone; captures and hands back the response.
// Optional macro S15850_N510_RESP_COMPARE_EN: compares the response against exp_resp and counts mismatches.
module s15850_n510_vec_driver #(
    parameter int VEC_W      = 21,
    parameter int CNT_W      = 5,
    parameter int SETTLE_CYC = 1
) (
    input  logic                      CK,
    input  logic                      RST,
    s15850_n510_vec_driver_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_APPLY   = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4,
        S_DELIVER = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] SHIFT_LAST  = CNT_W'(VEC_W - 1);
    localparam logic [3:0]       SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
    localparam bit               SKIP_SETTLE = (SETTLE_CYC == 0);

    state_t           r_state;
    state_t           w_next;
    logic [VEC_W-1:0] r_sh;
    logic [VEC_W-1:0] r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_settle;
    logic             r_resp;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_count;

    // State register
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE so it is never queued
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_SHIFT;
                else           w_next = S_IDLE;
            end
            S_SHIFT: begin
                if (bus.scan_en && (r_cnt == SHIFT_LAST)) w_next = S_APPLY;
                else                                      w_next = S_SHIFT;
            end
            S_APPLY: begin
                if (SKIP_SETTLE) w_next = S_CAPTURE;
                else             w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settle == SETTLE_LAST) w_next = S_CAPTURE;
                else                         w_next = S_SETTLE;
            end
            S_CAPTURE: w_next = S_DELIVER;
            S_DELIVER: begin
                if (bus.resp_ready) w_next = S_IDLE;
                else                w_next = S_DELIVER;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: shift register, applied vector, response capture and handshake bookkeeping
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_sh     <= '0;
            r_vec    <= '0;
            r_cnt    <= '0;
            r_settle <= 4'd0;
            r_resp   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= 16'd0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) r_cnt <= '0;
                end
                S_SHIFT: begin
                    // LSB first: the first bit ends up in bit 0 after VEC_W shifts
                    if (bus.scan_en) begin
                        r_sh  <= {bus.scan_in, r_sh[VEC_W-1:1]};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_APPLY: begin
                    r_vec    <= r_sh;
                    r_settle <= 4'd0;
                end
                S_SETTLE: r_settle <= r_settle + 4'd1;
                S_CAPTURE: begin
                    r_resp  <= bus.cone_resp;
                    r_valid <= 1'b1;
                end
                S_DELIVER: begin
                    if (bus.resp_ready) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vec_out    = r_vec;
    assign bus.resp_out   = r_resp;
    assign bus.resp_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.vec_count  = r_count;

`ifdef S15850_N510_RESP_COMPARE_EN
    logic       r_mis;
    logic [7:0] r_mis_cnt;
    logic       w_mis;

    assign w_mis = bus.cone_resp ^ bus.exp_resp;

    // Mismatch flag and saturating mismatch counter, updated only in CAPTURE
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_mis     <= 1'b0;
            r_mis_cnt <= 8'd0;
        end else if (r_state == S_CAPTURE) begin
            r_mis <= w_mis;
            if (w_mis && (r_mis_cnt != 8'hFF)) r_mis_cnt <= r_mis_cnt + 8'd1;
        end
    end

    assign bus.mismatch     = r_mis;
    assign bus.mismatch_cnt = r_mis_cnt;
`endif
endmodule

// File: tb/tb_s15850_n510_vec_driver.sv
// Directed bench for s15850_n510_vec_driver: one DUT with SETTLE_CYC=1 and one with SETTLE_CYC=0.
module tb_s15850_n510_vec_driver;
    logic CK;
    logic RST;
    logic sel0;
    logic start, scan_in, scan_en, cone_resp, resp_ready, exp_resp;
    int   n_vec;
    int   n_miss;

    s15850_n510_vec_driver_if #(.VEC_W(21)) bus1 ();
    s15850_n510_vec_driver_if #(.VEC_W(21)) bus0 ();

    s15850_n510_vec_driver #(.VEC_W(21), .CNT_W(5), .SETTLE_CYC(1)) u_dut1 (.CK(CK), .RST(RST), .bus(bus1.slave));
    s15850_n510_vec_driver #(.VEC_W(21), .CNT_W(5), .SETTLE_CYC(0)) u_dut0 (.CK(CK), .RST(RST), .bus(bus0.slave));

    // sel0 routes the stimulus to the SETTLE_CYC=0 instance; the other one sees idle inputs
    assign bus1.start      = sel0 ? 1'b0 : start;
    assign bus1.scan_in    = scan_in;
    assign bus1.scan_en    = sel0 ? 1'b0 : scan_en;
    assign bus1.cone_resp  = cone_resp;
    assign bus1.resp_ready = sel0 ? 1'b0 : resp_ready;
    assign bus0.start      = sel0 ? start : 1'b0;
    assign bus0.scan_in    = scan_in;
    assign bus0.scan_en    = sel0 ? scan_en : 1'b0;
    assign bus0.cone_resp  = cone_resp;
    assign bus0.resp_ready = sel0 ? resp_ready : 1'b0;
`ifdef S15850_N510_RESP_COMPARE_EN
    assign bus1.exp_resp   = exp_resp;
    assign bus0.exp_resp   = exp_resp;
`endif

    logic [20:0] o_vec;
    logic        o_resp, o_valid, o_busy, o_done;
    logic [15:0] o_cnt;
    assign o_vec   = sel0 ? bus0.vec_out    : bus1.vec_out;
    assign o_resp  = sel0 ? bus0.resp_out   : bus1.resp_out;
    assign o_valid = sel0 ? bus0.resp_valid : bus1.resp_valid;
    assign o_busy  = sel0 ? bus0.busy       : bus1.busy;
    assign o_done  = sel0 ? bus0.done       : bus1.done;
    assign o_cnt   = sel0 ? bus0.vec_count  : bus1.vec_count;

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic shift_bits(input logic [20:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            scan_en = 1'b1;
            scan_in = v[i];
            tick();
        end
        scan_en = 1'b0;
    endtask

    task automatic test_reset;
        n_vec++;
        if ({bus1.vec_out, bus1.resp_out, bus1.resp_valid, bus1.busy, bus1.done, bus1.vec_count} !== 41'd0) begin
            n_miss++;
            $display("FAIL reset_dut1: got %h want 0", {bus1.vec_out, bus1.resp_out, bus1.resp_valid, bus1.busy, bus1.done, bus1.vec_count});
        end
        n_vec++;
        if ({bus0.vec_out, bus0.resp_out, bus0.resp_valid, bus0.busy, bus0.done, bus0.vec_count} !== 41'd0) begin
            n_miss++;
            $display("FAIL reset_dut0: got %h want 0", {bus0.vec_out, bus0.resp_out, bus0.resp_valid, bus0.busy, bus0.done, bus0.vec_count});
        end
    endtask

    task automatic test_basic_hold;
        cone_resp = 1'b1;
        do_start();
        shift_bits(21'h1ABCDE, 0, 20);
        n_vec++;
        if (o_vec !== 21'h000000 || o_busy !== 1'b1) begin
            n_miss++;
            $display("FAIL basic_pre_apply: vec %h busy %b want 000000 1", o_vec, o_busy);
        end
        tick();
        n_vec++;
        if (o_vec !== 21'h1ABCDE || o_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_apply: vec %h valid %b want 1abcde 0", o_vec, o_valid);
        end
        tick();
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_early_valid: valid %b want 0", o_valid);
        end
        tick();
        n_vec++;
        if (o_valid !== 1'b1 || o_resp !== 1'b1) begin
            n_miss++;
            $display("FAIL basic_latency: valid %b resp %b want 1 1", o_valid, o_resp);
        end
        for (int k = 0; k < 4; k++) begin
            cone_resp = ~cone_resp;
            tick();
            n_vec++;
            if (o_valid !== 1'b1 || o_resp !== 1'b1 || o_done !== 1'b0 || o_cnt !== 16'd0) begin
                n_miss++;
                $display("FAIL hold_stable: valid %b resp %b done %b cnt %0d want 1 1 0 0", o_valid, o_resp, o_done, o_cnt);
            end
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++;
        if (o_done !== 1'b1 || o_valid !== 1'b0 || o_cnt !== 16'd1 || o_busy !== 1'b0) begin
            n_miss++;
            $display("FAIL hold_handshake: done %b valid %b cnt %0d busy %b want 1 0 1 0", o_done, o_valid, o_cnt, o_busy);
        end
        tick();
        n_vec++;
        if (o_done !== 1'b0 || o_cnt !== 16'd1) begin
            n_miss++;
            $display("FAIL hold_done_pulse: done %b cnt %0d want 0 1", o_done, o_cnt);
        end
    endtask

    task automatic test_scan_gap;
        cone_resp = 1'b0;
        do_start();
        shift_bits(21'h0F0F0F, 0, 7);
        for (int k = 0; k < 5; k++) begin
            scan_in = ~scan_in;
            tick();
            n_vec++;
            if (o_busy !== 1'b1 || o_vec !== 21'h1ABCDE) begin
                n_miss++;
                $display("FAIL gap_hold: busy %b vec %h want 1 1abcde", o_busy, o_vec);
            end
        end
        shift_bits(21'h0F0F0F, 8, 20);
        tick();
        n_vec++;
        if (o_vec !== 21'h0F0F0F) begin
            n_miss++;
            $display("FAIL gap_vec: got %h want 0f0f0f", o_vec);
        end
        tick();
        tick();
        n_vec++;
        if (o_valid !== 1'b1 || o_resp !== 1'b0) begin
            n_miss++;
            $display("FAIL gap_resp: valid %b resp %b want 1 0", o_valid, o_resp);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++;
        if (o_cnt !== 16'd2 || o_done !== 1'b1) begin
            n_miss++;
            $display("FAIL gap_count: cnt %0d done %b want 2 1", o_cnt, o_done);
        end
    endtask

    task automatic test_settle0;
        sel0 = 1'b1;
        cone_resp = 1'b1;
        start = 1'b1;
        tick();
        shift_bits(21'h000000, 0, 20);
        n_vec++;
        if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL s0_busy: busy %b valid %b want 1 0", o_busy, o_valid);
        end
        tick();
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL s0_early_valid: valid %b want 0", o_valid);
        end
        tick();
        n_vec++;
        if (o_valid !== 1'b1 || o_resp !== 1'b1 || o_vec !== 21'h000000) begin
            n_miss++;
            $display("FAIL s0_latency: valid %b resp %b vec %h want 1 1 000000", o_valid, o_resp, o_vec);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        start = 1'b0;
        n_vec++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_cnt !== 16'd1) begin
            n_miss++;
            $display("FAIL s0_handshake: done %b busy %b cnt %0d want 1 0 1", o_done, o_busy, o_cnt);
        end
        tick();
        tick();
        n_vec++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_cnt !== 16'd1) begin
            n_miss++;
            $display("FAIL s0_single_done: done %b busy %b cnt %0d want 0 0 1", o_done, o_busy, o_cnt);
        end
        sel0 = 1'b0;
    endtask

    task automatic test_reset_mid_shift;
        do_start();
        shift_bits(21'h155555, 0, 9);
        RST = 1'b1;
        #1;
        n_vec++;
        if ({o_vec, o_resp, o_valid, o_busy, o_done, o_cnt} !== 41'd0) begin
            n_miss++;
            $display("FAIL rst_mid_shift: got %h want 0", {o_vec, o_resp, o_valid, o_busy, o_done, o_cnt});
        end
        #2;
        RST = 1'b0;
        tick();
        cone_resp = 1'b1;
        do_start();
        shift_bits(21'h012345, 0, 20);
        tick();
        n_vec++;
        if (o_vec !== 21'h012345) begin
            n_miss++;
            $display("FAIL rst_new_vec: got %h want 012345", o_vec);
        end
        tick();
        tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++;
        if (o_cnt !== 16'd1 || o_done !== 1'b1) begin
            n_miss++;
            $display("FAIL rst_count: cnt %0d done %b want 1 1", o_cnt, o_done);
        end
        tick();
    endtask

`ifdef S15850_N510_RESP_COMPARE_EN
    task automatic test_compare;
        logic [1:0] pairs [3];
        logic       exp_mis [3];
        logic [7:0] exp_cnt [3];
        pairs[0] = 2'b10; pairs[1] = 2'b00; pairs[2] = 2'b01;
        exp_mis[0] = 1'b1; exp_mis[1] = 1'b0; exp_mis[2] = 1'b1;
        exp_cnt[0] = 8'd1; exp_cnt[1] = 8'd1; exp_cnt[2] = 8'd2;
        for (int p = 0; p < 3; p++) begin
            cone_resp = pairs[p][1];
            exp_resp  = pairs[p][0];
            do_start();
            shift_bits(21'h0A5A5A, 0, 20);
            tick();
            tick();
            tick();
            n_vec++;
            if (bus1.mismatch !== exp_mis[p] || bus1.mismatch_cnt !== exp_cnt[p] || o_valid !== 1'b1) begin
                n_miss++;
                $display("FAIL compare_%0d: mismatch %b cnt %0d valid %b want %b %0d 1",
                         p, bus1.mismatch, bus1.mismatch_cnt, o_valid, exp_mis[p], exp_cnt[p]);
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            tick();
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_miss = 0;
        RST = 1'b1;
        sel0 = 1'b0;
        start = 1'b0;
        scan_in = 1'b0;
        scan_en = 1'b0;
        cone_resp = 1'b0;
        resp_ready = 1'b0;
        exp_resp = 1'b0;
        tick();
        tick();
        test_reset();
        RST = 1'b0;
        tick();
        test_basic_hold();
        test_scan_gap();
        test_settle0();
        test_reset_mid_shift();
`ifdef S15850_N510_RESP_COMPARE_EN
        test_compare();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
